// File: rtl/ripple_carry_adder_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
package ripple_carry_adder_pkg;

    // Default operand width and the largest width the adder supports.
    localparam int RCA_DEFAULT_WIDTH = 4;
    localparam int RCA_MAX_WIDTH     = 32;

    // {cout, sum} result container sized for the widest legal adder.
    // Narrower instances occupy the low WIDTH+1 bits.
    typedef logic [RCA_MAX_WIDTH:0] rca_result_t;

endpackage : ripple_carry_adder_pkg

// File: rtl/ripple_carry_adder_reg_full_adder_cell.sv
// Single-bit full adder: one stage of the ripple-carry chain.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    // Sum and majority carry for one bit position.
    always_comb begin
        s  = a ^ b ^ ci;
        co = (a & b) | (a & ci) | (b & ci);
    end

endmodule : full_adder_cell

// File: rtl/ripple_carry_adder_reg.sv
// Registered N-bit ripple-carry adder: {cout, sum} = a + b + cin,
// captured one cycle after in_valid and flagged with out_valid.
// Optional build macro RIPPLE_CARRY_ADDER_OVF_EN adds a registered
// two's-complement overflow output (ovf).
module ripple_carry_adder_reg
    import ripple_carry_adder_pkg::*;
#(
    parameter int WIDTH = RCA_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    // Refuse to build an adder of unsupported width.
    generate
        if (WIDTH < 1 || WIDTH > RCA_MAX_WIDTH) begin : g_width_check
            $error("ripple_carry_adder_reg: WIDTH must be in 1..%0d", RCA_MAX_WIDTH);
        end
    endgenerate

    // carry[i] is the carry into bit i; carry[WIDTH] is the adder carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;

    logic             out_valid_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    assign carry[0] = cin;

    // One full-adder cell per bit, each feeding its carry to the next.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder_cell u_cell (
                .a  (a[gi]),
                .b  (b[gi]),
                .ci (carry[gi]),
                .s  (sum_d[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    // Result register: load only on in_valid so idle (even unknown) inputs
    // leave the last result untouched; reset clears everything.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
        end else begin
            out_valid_q <= in_valid;
            if (in_valid) begin
                sum_q  <= sum_d;
                cout_q <= carry[WIDTH];
            end
        end
    end

    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;

`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    logic ovf_q;
    logic ovf_d;

    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf_d = carry[WIDTH] ^ carry[WIDTH-1];

    // Overflow flag registered alongside the sum with the same load enable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (in_valid) begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = ovf_q;
`endif

endmodule : ripple_carry_adder_reg

// File: tb/tb_ripple_carry_adder_reg.sv
// Scoreboard bench for ripple_carry_adder_reg at WIDTH=4 with
// hand-computed directed vectors.
module tb_ripple_carry_adder_reg;
    import ripple_carry_adder_pkg::*;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
    logic         ovf;
`endif

    int   total;
    int   bad;
    int   pushed;
    int   popped;
    exp_t exp_q[$];

    ripple_carry_adder_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .sum       (sum),
        .cout      (cout)
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    // Drive one operation with its hand-computed expected result.
    task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input logic [W-1:0] es, input logic ec, input logic eo);
        exp_t e;
        rca_result_t r;
        in_valid = 1'b1;
        a        = ta;
        b        = tb;
        cin      = tc;
        e.sum    = es;
        e.cout   = ec;
        e.ovf    = eo;
        r        = {28'd0, ec, es};
        exp_q.push_back(e);
        pushed++;
        $display("issue a=%b b=%b cin=%b expect cout,sum=%b", ta, tb, tc, r[W:0]);
        @(posedge clk);
        #1;
    endtask

    // Monitor: every out_valid cycle is matched against the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: out_valid=1 with no pending result sum=%b", sum);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                popped++;
                $display("result sum=%b cout=%b (want %b %b)", sum, cout, e.sum, e.cout);
                check("sum", 32'(sum), 32'(e.sum));
                check("cout", 32'(cout), 32'(e.cout));
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Hard bound so the run always terminates.
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin
        total    = 0;
        bad      = 0;
        pushed   = 0;
        popped   = 0;
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'b1111;
        b        = 4'b1111;
        cin      = 1'b1;

        // Reset dominates in_valid for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        $display("reset out_valid=%b sum=%b cout=%b", out_valid, sum, cout);

        // Release: the next edge captures the pending operands.
        rst_n = 1'b1;
        issue(4'b1111, 4'b1111, 1'b1, 4'b1111, 1'b1, 1'b0);

        // Back-to-back directed vectors.
        issue(4'b0010, 4'b1010, 1'b1, 4'b1101, 1'b0, 1'b0);
        issue(4'b1010, 4'b0010, 1'b0, 4'b1100, 1'b0, 1'b0);
        issue(4'b1010, 4'b0001, 1'b1, 4'b1100, 1'b0, 1'b0);
        issue(4'b0010, 4'b1000, 1'b0, 4'b1010, 1'b0, 1'b0);
        issue(4'b0011, 4'b1100, 1'b1, 4'b0000, 1'b1, 1'b0);

        // Hold: idle operands must not disturb the last result.
        in_valid = 1'b0;
        a        = 4'b1111;
        b        = 4'b1111;
        cin      = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("hold_out_valid", 32'(out_valid), 32'd0);
        check("hold_sum", 32'(sum), 32'd0);
        check("hold_cout", 32'(cout), 32'd1);
        $display("hold out_valid=%b sum=%b cout=%b", out_valid, sum, cout);

        a   = 'x;
        b   = 'x;
        cin = 'x;
        @(posedge clk);
        @(negedge clk);
        check("idlex_sum", 32'(sum), 32'd0);
        check("idlex_cout", 32'(cout), 32'd1);
        $display("idle-x out_valid=%b sum=%b cout=%b", out_valid, sum, cout);
        @(posedge clk);
        #1;

        // Carry propagation and signed-overflow cases.
        issue(4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0);
        issue(4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1);
        issue(4'b1000, 4'b1000, 1'b0, 4'b0000, 1'b1, 1'b1);
        issue(4'b0101, 4'b0110, 1'b0, 4'b1011, 1'b0, 1'b1);
        issue(4'b0011, 4'b1100, 1'b1, 4'b0000, 1'b1, 1'b0);
        issue(4'b0010, 4'b1010, 1'b1, 4'b1101, 1'b0, 1'b0);

        // Mid-stream reset with in_valid still high clears the outputs.
        rst_n    = 1'b0;
        in_valid = 1'b1;
        a        = 4'b1111;
        b        = 4'b1111;
        cin      = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_cout", 32'(cout), 32'd0);
`ifdef RIPPLE_CARRY_ADDER_OVF_EN
        check("midrst_ovf", 32'(ovf), 32'd0);
`endif
        $display("mid-reset out_valid=%b sum=%b cout=%b", out_valid, sum, cout);

        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Every issued operation must have produced exactly one result.
        check("results_drained", 32'(popped), 32'(pushed));
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_ripple_carry_adder_reg

// File: doc/ripple_carry_adder_reg.md
Name: ripple_carry_adder_reg

Overview:
- Registered N-bit ripple-carry adder: sum = a + b + cin, with carry-out.
- The combinational datapath is a chain of single-bit full-adder cells, each cell's carry feeding the next.
- Results are captured in an output register, qualified by a valid flag.
- Used as a small arithmetic leaf in datapaths that need a registered add with explicit carry-in/carry-out.

Parameters:
- WIDTH, 4, operand and sum bit width; legal range 1..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands valid this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum/cout hold a result captured on the previous edge.
- sum  output  WIDTH  registered sum bits.
- cout  output  1  registered carry out of bit WIDTH-1.

Behaviour:
- Reset: sampled only on a rising clk edge with rst_n=0.
  - Reset values: sum=0, cout=0, out_valid=0.
  - Reset dominates in_valid in the same cycle.
  - Asserting reset mid-stream discards any result captured but not yet consumed.
- Combinational ripple, for i = 0..WIDTH-1:
  - c[0] = cin.
  - s[i] = a[i] ^ b[i] ^ c[i].
  - c[i+1] = (a[i]&b[i]) | (a[i]&c[i]) | (b[i]&c[i]).
  - Carry-out = c[WIDTH].
  - Result is arithmetically identical to the (WIDTH+1)-bit value {cout,sum} = a + b + cin.
- Latency: exactly 1 cycle.
  - If in_valid=1 at edge k, sum/cout show the result after edge k and out_valid=1.
  - If in_valid=0 at an edge, out_valid=0 and sum/cout hold their previous values (no update).
- Throughput: one operation per cycle. Back-to-back in_valid produces back-to-back out_valid with no bubbles.
- No backpressure: the consumer must accept every out_valid cycle.
- Wrap-around: the sum is modulo 2^WIDTH and the overflow bit appears on cout.
  - Example at WIDTH=4: 1111+0000+1 gives sum=0000, cout=1.
- Unknown (X) inputs while in_valid=0 must not affect the registered outputs.

Optional Feature:
- Macro: RIPPLE_CARRY_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit), registered alongside sum, reset value 0.
  - ovf = c[WIDTH] ^ c[WIDTH-1], i.e. two's-complement signed overflow of a + b + cin.
  - ovf updates only when in_valid=1.
- Undefined:
  - No ovf port and no associated logic.
  - All other behaviour is unchanged.

Decomposition:
- Package ripple_carry_adder_pkg:
  - RCA_DEFAULT_WIDTH = 4.
  - RCA_MAX_WIDTH = 32.
  - Typedef for the (WIDTH+1)-bit {cout,sum} result.
- Sub-module full_adder_cell:
  - Ports a, b, ci; outputs s, co.
  - Purely combinational.
  - Instantiated WIDTH times in a generate loop, carries chained.
- The top level holds the carry vector, the output register and the optional ovf logic.
- Elaboration check: reject WIDTH outside 1..RCA_MAX_WIDTH.

Test Plan:
- Reset:
  - Hold rst_n=0 for 2 edges with in_valid=1, a=1111, b=1111, cin=1 -> sum=0000, cout=0, out_valid=0.
  - Release rst_n -> the next edge captures the result.
- Directed vectors, WIDTH=4, one per cycle with in_valid=1, each checked 1 cycle later with out_valid=1:
  - a=0010, b=1010, cin=1 -> sum=1101, cout=0.
  - a=1010, b=0010, cin=0 -> sum=1100, cout=0.
  - a=0011, b=1100, cin=1 -> sum=0000, cout=1.
  - a=1010, b=0001, cin=1 -> sum=1100, cout=0.
  - a=0010, b=1000, cin=0 -> sum=1010, cout=0.
- Hold behaviour:
  - After a=0011, b=1100, cin=1, drop in_valid and drive a=1111, b=1111 -> out_valid=0, sum stays 0000, cout stays 1.
- Full carry propagation: a=1111, b=0000, cin=1 -> sum=0000, cout=1. Also a=1111, b=1111, cin=1 -> sum=1111, cout=1.
- Reset mid-stream: in_valid=1 result captured, then rst_n=0 for one edge -> outputs cleared to 0 and out_valid=0 on that edge.
- RIPPLE_CARRY_ADDER_OVF_EN defined:
  - a=0111, b=0001, cin=0 -> sum=1000, ovf=1.
  - a=0011, b=1100, cin=1 -> sum=0000, ovf=0.
  - a=1000, b=1000, cin=0 -> sum=0000, cout=1, ovf=1.
